vga_demo_sequencer: RTL and testbench

Autonomous mode sequencer that sits in front of the VGA pattern `controller`. It steps the controller's 3-bit pattern mode through its slots every N frames. Each step reloads the controller's latched mode parameters by pulsing its reset with the VGA timing mask asserted, so sync timing is never disturbed. When disabled, it passes the user inputs straight through.

---
 rtl/vga_demo_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vga_demo_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_demo_sequencer.sv
// ============================================================================
// vga_demo_sequencer
//
// Purpose:
//   Autonomous mode sequencer placed in front of the VGA pattern controller.
//   When enabled, it steps the controller's 3-bit pattern mode through its
//   slots every N frames. Each step reloads the controller's latched mode
//   parameters by pulsing the controller reset with the VGA timing mask
//   asserted, so the sync timing keeps running undisturbed. When disabled,
//   the user inputs pass straight through and the sequencer is frozen.
//
// Parameters:
//   DWELL_W      width of the frame dwell counter and the dwell port
//   LOAD_CYCLES  cycles ctrl_rst_n is held low per reload (>= 1)
//
// Ports:
//   clk           in   pixel clock, shared with the controller
//   reset         in   synchronous active-high reset
//   enable        in   1 = auto-sequencing, 0 = passthrough / frozen
//   ui_in         in   [7:0] user inputs (bit 7 timing mode, 3:0 sub-params)
//   frame_end     in   one-cycle pulse from the controller at end of frame
//   step          in   pulse: force a mode change at the next frame_end
//   dwell         in   [DWELL_W-1:0] frames per slot, 0 behaves as 1
//   ui_out        out  [7:0] drives the controller ui_in
//   ctrl_rst_n    out  registered, drives the controller rst_n
//   rst_vga_mask  out  registered, drives the controller rst_vga_mask
//   slot          out  [2:0] current mode slot
//   busy          out  high whenever the sequencer is not in DWELL
//
// Configuration macro:
//   VGA_DEMO_SEQ_SKIP_UNUSED_EN  when defined, the slot sequence skips the
//                                unused modes 3 and 7.
// ============================================================================
module vga_demo_sequencer #(
    parameter int DWELL_W     = 8,
    parameter int LOAD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         ui_in,
    input  logic               frame_end,
    input  logic               step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         ui_out,
    output logic               ctrl_rst_n,
    output logic               rst_vga_mask,
    output logic [2:0]         slot,
    output logic               busy
);

    // The load counter only needs to reach LOAD_CYCLES-1.
    localparam int              LC_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOAD_CYCLES - 1);
    localparam logic [LC_W-1:0] LC_ONE  = LC_W'(1);
    localparam logic [DWELL_W:0] DW_ONE = (DWELL_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DWELL = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             state;
    logic [LC_W-1:0]    load_cnt;
    logic [DWELL_W-1:0] frame_cnt;
    logic               step_pend;

    logic [DWELL_W:0]   frame_next;
    logic [DWELL_W:0]   dwell_eff;
    logic               switch_now;
    logic [2:0]         slot_next;

    // Next slot in the rotation; optionally hops over the unused modes.
    function automatic logic [2:0] next_slot(input logic [2:0] cur);
        logic [2:0] inc;
        logic [2:0] res;
        inc = cur + 3'd1;
`ifdef VGA_DEMO_SEQ_SKIP_UNUSED_EN
        res = (inc == 3'd3 || inc == 3'd7) ? inc + 3'd1 : inc;
`else
        res = inc;
`endif
        return res;
    endfunction

    // Compare in DWELL_W+1 bits so a saturated counter still triggers a
    // switch instead of wrapping to a small value.
    always_comb begin
        frame_next = {1'b0, frame_cnt} + DW_ONE;
        dwell_eff  = (dwell == '0) ? DW_ONE : {1'b0, dwell};
        switch_now = frame_end && ((frame_next >= dwell_eff) || step_pend || step);
        slot_next  = next_slot(slot);
    end

    // With the sequencer active the mode bits come from the slot, which also
    // hides the controller's live voffset modulation on those bits.
    assign ui_out = enable ? {ui_in[7], slot, ui_in[3:0]} : ui_in;

    // Sequencer FSM. Outputs are registered alongside the state so that
    // ctrl_rst_n, rst_vga_mask and busy change on the same edge as state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            load_cnt     <= '0;
            frame_cnt    <= '0;
            step_pend    <= 1'b0;
            slot         <= 3'd0;
            ctrl_rst_n   <= 1'b0;
            rst_vga_mask <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    // Full controller reset including sync; step is ignored.
                    if (load_cnt == LC_LAST) begin
                        state      <= ST_DWELL;
                        load_cnt   <= '0;
                        ctrl_rst_n <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        load_cnt <= load_cnt + LC_ONE;
                    end
                end

                ST_LOAD: begin
                    // frame_end is ignored here; a step is remembered unless
                    // the sequencer has been disabled meanwhile.
                    if (!enable) begin
                        step_pend <= 1'b0;
                    end else if (step) begin
                        step_pend <= 1'b1;
                    end
                    if (load_cnt == LC_LAST) begin
                        state        <= ST_DWELL;
                        load_cnt     <= '0;
                        ctrl_rst_n   <= 1'b1;
                        rst_vga_mask <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        load_cnt <= load_cnt + LC_ONE;
                    end
                end

                ST_DWELL: begin
                    if (!enable) begin
                        frame_cnt <= '0;
                        step_pend <= 1'b0;
                    end else if (switch_now) begin
                        slot         <= slot_next;
                        frame_cnt    <= '0;
                        step_pend    <= 1'b0;
                        state        <= ST_LOAD;
                        load_cnt     <= '0;
                        ctrl_rst_n   <= 1'b0;
                        rst_vga_mask <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        if (step) begin
                            step_pend <= 1'b1;
                        end
                        if (frame_end && (frame_cnt != '1)) begin
                            frame_cnt <= frame_next[DWELL_W-1:0];
                        end
                    end
                end

                default: begin
                    state        <= ST_INIT;
                    load_cnt     <= '0;
                    ctrl_rst_n   <= 1'b0;
                    rst_vga_mask <= 1'b0;
                    busy         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_demo_sequencer.sv
// ============================================================================
// tb_vga_demo_sequencer
//
// Purpose:
//   Self-checking bench for vga_demo_sequencer. Each driven cycle pushes the
//   expected outputs of a small reference model onto a queue; after the
//   clock edge the entry is popped and compared with the DUT outputs.
//   Directed scenarios add constant checks for the documented behaviour.
//
// Ports: none (top-level bench).
// Honours VGA_DEMO_SEQ_SKIP_UNUSED_EN for the expected slot order.
// ============================================================================
module tb_vga_demo_sequencer;

    localparam int DWELL_W     = 8;
    localparam int LOAD_CYCLES = 2;

    localparam int P_INIT  = 0;
    localparam int P_DWELL = 1;
    localparam int P_LOAD  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [7:0]         ui_in;
    logic               frame_end;
    logic               step;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         ui_out;
    logic               ctrl_rst_n;
    logic               rst_vga_mask;
    logic [2:0]         slot;
    logic               busy;

    vga_demo_sequencer #(
        .DWELL_W     (DWELL_W),
        .LOAD_CYCLES (LOAD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ui_in        (ui_in),
        .frame_end    (frame_end),
        .step         (step),
        .dwell        (dwell),
        .ui_out       (ui_out),
        .ctrl_rst_n   (ctrl_rst_n),
        .rst_vga_mask (rst_vga_mask),
        .slot         (slot),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ui_out;
        logic       ctrl_rst_n;
        logic       rst_vga_mask;
        logic [2:0] slot;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Current stimulus settings held between cycles.
    logic       cur_rst = 1'b1;
    logic       cur_en  = 1'b1;
    logic [7:0] cur_ui  = 8'h00;
    logic [7:0] cur_dw  = 8'd1;

    // Reference model state.
    int         m_phase  = P_INIT;
    int         m_left   = LOAD_CYCLES;
    int         m_frames = 0;
    logic       m_pend   = 1'b0;
    logic [2:0] m_slot   = 3'd0;

    int seq_exp[8];
    int cnt;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [2:0] nextSlot(input logic [2:0] s);
        logic [2:0] n;
        n = s + 3'd1;
`ifdef VGA_DEMO_SEQ_SKIP_UNUSED_EN
        if (n == 3'd3 || n == 3'd7) n = n + 3'd1;
`endif
        return n;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic modelStep(input logic fe, input logic st);
        int thr;
        if (cur_rst) begin
            m_phase  = P_INIT;
            m_left   = LOAD_CYCLES;
            m_slot   = 3'd0;
            m_frames = 0;
            m_pend   = 1'b0;
        end else if (m_phase == P_INIT) begin
            m_left--;
            if (m_left == 0) m_phase = P_DWELL;
        end else if (m_phase == P_LOAD) begin
            if (!cur_en) m_pend = 1'b0;
            else if (st) m_pend = 1'b1;
            m_left--;
            if (m_left == 0) m_phase = P_DWELL;
        end else begin
            thr = (cur_dw == 8'd0) ? 1 : int'(cur_dw);
            if (!cur_en) begin
                m_frames = 0;
                m_pend   = 1'b0;
            end else if (fe && ((m_frames + 1 >= thr) || m_pend || st)) begin
                m_slot   = nextSlot(m_slot);
                m_frames = 0;
                m_pend   = 1'b0;
                m_phase  = P_LOAD;
                m_left   = LOAD_CYCLES;
            end else begin
                if (st) m_pend = 1'b1;
                if (fe && m_frames < 255) m_frames++;
            end
        end
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic checkScoreboard();
        exp_t e;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL sb_empty: got no expectation, expected one queued");
            return;
        end
        e = exp_q.pop_front();
        checkOutput("sb_ui_out", ui_out, e.ui_out);
        checkOutput("sb_ctrl_rst_n", ctrl_rst_n, e.ctrl_rst_n);
        checkOutput("sb_rst_vga_mask", rst_vga_mask, e.rst_vga_mask);
        checkOutput("sb_slot", slot, e.slot);
        checkOutput("sb_busy", busy, e.busy);
    endtask

    // Drive one cycle at the falling edge, queue the expected result, then
    // compare just after the rising edge and return at the next falling edge.
    task automatic applyStimulus(input logic fe, input logic st);
        exp_t e;
        reset     = cur_rst;
        enable    = cur_en;
        ui_in     = cur_ui;
        dwell     = cur_dw;
        frame_end = fe;
        step      = st;
        modelStep(fe, st);
        e.ui_out       = cur_en ? {cur_ui[7], m_slot, cur_ui[3:0]} : cur_ui;
        e.ctrl_rst_n   = (m_phase == P_DWELL);
        e.rst_vga_mask = (m_phase == P_LOAD);
        e.slot         = m_slot;
        e.busy         = (m_phase != P_DWELL);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkScoreboard();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
`ifdef VGA_DEMO_SEQ_SKIP_UNUSED_EN
        seq_exp = '{1, 2, 4, 5, 6, 0, 1, 2};
`else
        seq_exp = '{1, 2, 3, 4, 5, 6, 7, 0};
`endif
        reset = 1'b1; enable = 1'b1; ui_in = 8'h00;
        frame_end = 1'b0; step = 1'b0; dwell = 8'd1;
        @(negedge clk);

        // Reset, then basic dwell=3 behaviour.
        cur_rst = 1'b1; cur_en = 1'b1; cur_dw = 8'd3; cur_ui = 8'h85;
        idle(2);
        checkOutput("rst_ctrl_rst_n", ctrl_rst_n, 1'b0);
        checkOutput("rst_mask", rst_vga_mask, 1'b0);
        checkOutput("rst_busy", busy, 1'b1);
        checkOutput("rst_slot", slot, 3'd0);
        cur_rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8 && ctrl_rst_n == 1'b0; i++) begin
            cnt++;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("init_low_cycles", cnt, 2);
        checkOutput("ui_out_passslot", ui_out, 8'h85);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            if (k < 2) begin
                checkOutput("dwell3_noswitch", slot, 3'd0);
                idle(3);
            end
        end
        checkOutput("dwell3_slot", slot, 3'd1);
        checkOutput("dwell3_ui_out", ui_out, 8'h95);
        cnt = 0;
        for (int i = 0; i < 8 && rst_vga_mask == 1'b1; i++) begin
            cnt++;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("load_mask_cycles", cnt, 2);

        // dwell=0: switch on every frame_end from a fresh reset.
        cur_rst = 1'b1; idle(1); cur_rst = 1'b0;
        idle(3);
        cur_dw = 8'd0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("seq_%0d", i), slot, seq_exp[i]);
            idle(3);
        end

        // Long dwell with a step pulse mid-frame, then counter restart.
        cur_dw = 8'd200;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            idle(2);
        end
        checkOutput("dwell200_noswitch", busy, 1'b0);
        applyStimulus(1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("step_switch", rst_vga_mask, 1'b1);
        idle(3);
        cur_dw = 8'd3;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("restart_f%0d", k), rst_vga_mask, (k == 2) ? 1'b1 : 1'b0);
            if (k < 2) idle(2);
        end

        // frame_end during LOAD must not be counted (dwell=2).
        cur_dw = 8'd2;
        applyStimulus(1'b1, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("load_fe_ignored", rst_vga_mask, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("load_fe_second", rst_vga_mask, 1'b1);
        idle(3);

        // Disabled: passthrough, no reloads, pending step discarded.
        cur_en = 1'b0; cur_ui = 8'h3C; cur_dw = 8'd1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("dis_passthru", ui_out, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("dis_noload", rst_vga_mask, 1'b0);
            applyStimulus(1'b0, 1'b1);
            idle(2);
        end
        cur_en = 1'b1; cur_ui = 8'h85; cur_dw = 8'd2;
        idle(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reen_first", rst_vga_mask, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reen_second", rst_vga_mask, 1'b1);
        idle(3);

        // Reset asserted in the second LOAD cycle.
        cur_dw = 8'd1;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        cur_rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("midload_slot", slot, 3'd0);
        checkOutput("midload_mask", rst_vga_mask, 1'b0);
        checkOutput("midload_rstn", ctrl_rst_n, 1'b0);
        cur_rst = 1'b0;
        idle(3);

        // Random mix of frames, steps, enables, dwell values and resets.
        for (int i = 0; i < 600; i++) begin
            cur_en  = ($urandom_range(0, 15) != 0);
            cur_dw  = 8'($urandom_range(0, 3));
            cur_ui  = 8'($urandom_range(0, 255));
            cur_rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        cur_rst = 1'b0;
        idle(4);

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
